imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Upstream feeder for MipsPipelineTop.
- Accepts a valid/ready stream of 32-bit program words, writes them sequentially into instruction memory, then releases the core's active-high reset after a fixed delay.
- Replaces hard-coded memory init, so benches and the FPGA top can load programs at run time.
- Holds the core in reset whenever no valid program is loaded.

Parameters:
- ADDR_W, 8, instruction-memory word-address width (capacity 2^ADDR_W words)
- DATA_W, 32, instruction word width
- BASE_ADDR, 0, first word address written
- RELEASE_DELAY, 4, cycles between the final write and core_reset deassertion (legal range 1..15)

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins a load
- s_valid  in  1  stream word valid
- s_ready  out  1  loader accepts a word
- s_data  in  DATA_W  program word
- s_last  in  1  marks the final word of the program
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  DATA_W  write data
- core_reset  out  1  active-high reset to MipsPipelineTop
- busy  out  1  high in LOAD or DRAIN
- done  out  1  high in RUN
- error  out  1  high in ERROR
- word_count  out  ADDR_W+1  words accepted in the current load

Behaviour:
- Reset values: s_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, core_reset=1, busy=0, done=0, error=0, word_count=0, state=IDLE.
- FSM states: IDLE, LOAD, DRAIN, RUN, ERROR. One-hot or binary encoding is acceptable.
- IDLE:
  - core_reset=1, s_ready=0.
  - start -> LOAD. On entry, word_count clears to 0 and the write pointer loads BASE_ADDR.
- LOAD:
  - s_ready=1 combinationally from state; it does not depend on s_valid.
  - A handshake is s_valid & s_ready.
  - Each handshake registers imem_we=1, imem_addr=pointer, imem_wdata=s_data on the next edge, so write latency is exactly 1 cycle.
  - Each handshake then increments the pointer and word_count.
  - imem_we is low on every cycle without a handshake.
- Handshake with s_last=1: the word is written normally; next state DRAIN, s_ready drops next cycle.
- Overflow: a handshake when word_count == 2^ADDR_W goes to ERROR. That word is not written and the pointer does not wrap.
- DRAIN:
  - Counter runs 0..RELEASE_DELAY-1.
  - On expiry -> RUN: core_reset=0 and done=1 on the same edge.
  - The final imem write completes before DRAIN's first cycle ends.
- RUN: core_reset=0. start -> LOAD, and core_reset=1 is registered on that same edge.
- ERROR: core_reset=1, error=1. Only start (-> LOAD, error clears) or reset exits.
- start while in LOAD or DRAIN is ignored.
- Async reset mid-load:
  - All outputs return to reset values immediately.
  - Partially written memory is left as-is; the core stays held.
- s_data, s_valid and s_last are only sampled on handshake cycles.

Optional Feature:
- Macro: IMEM_BOOT_CHECKSUM_EN.
- When defined:
  - Adds input expected_sum[DATA_W-1:0] and output calc_sum[DATA_W-1:0].
  - calc_sum is a modulo-2^DATA_W running sum of accepted words, cleared on entry to LOAD.
  - On the s_last handshake, if calc_sum + s_data != expected_sum, the word is still written but the next state is ERROR, not DRAIN.
- When undefined: no extra ports; s_last always proceeds to DRAIN.

Decomposition:
- Package imem_boot_pkg holds:
  - state enum: IDLE, LOAD, DRAIN, RUN, ERROR
  - default widths ADDR_W_DEF=8, DATA_W_DEF=32
  - RELEASE_DELAY_MAX=15
- One natural sub-module: boot_release_timer, a 4-bit load/count/expire counter used in DRAIN.
- Top-level FSM, pointer and write register stay in imem_boot_loader.

Test Plan:
- Reset low for 2 cycles, then high -> all outputs at reset values, core_reset=1, state IDLE.
- start, then 3 words 0x20080005, 0x20090003, 0x01095020 (last on the third) -> imem_we pulses at addr 0,1,2 one cycle after each handshake; word_count=3; done=1 and core_reset=0 exactly 4 cycles after the last write.
- s_valid toggled 1,0,1,1,0,1 during LOAD -> exactly 4 writes, contiguous addresses, no write on idle cycles.
- ADDR_W=2: 5 words with s_last on the 5th -> 4 writes at addr 0..3; 5th handshake -> error=1, no write, core_reset stays 1.
- Reset asserted while in DRAIN, then start with 1 word -> immediate return to reset values; the reload writes addr 0 and the release follows normally.
- With IMEM_BOOT_CHECKSUM_EN: words 1,2,3 with expected_sum=6 -> RUN; same words with expected_sum=7 -> ERROR, core_reset=1.

Source files
------------

// File: rtl/imem_boot_pkg.sv
// Shared types and defaults for the instruction-memory boot loader.
// Optional build macro: IMEM_BOOT_CHECKSUM_EN.
package imem_boot_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;
  localparam int RELEASE_DELAY_MAX = 15;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    RUN,
    ERROR
  } boot_state_t;

endpackage

// File: rtl/imem_boot_loader_timer.sv
// Release timer: 4-bit load/count/expire counter used while draining.
// Expires on the DELAY-th enabled cycle after a load.
module boot_release_timer #(
  parameter int DELAY = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam logic [3:0] LAST = 4'(DELAY - 1);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign expire = en && (cnt == LAST);

endmodule

// File: rtl/imem_boot_loader.sv
// Streams program words into instruction memory, then releases core reset.
// Optional build macro: IMEM_BOOT_CHECKSUM_EN (expected_sum / calc_sum).
module imem_boot_loader
  import imem_boot_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int BASE_ADDR     = 0,
  parameter int RELEASE_DELAY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
`ifdef IMEM_BOOT_CHECKSUM_EN
  input  logic [DATA_W-1:0] expected_sum,
  output logic [DATA_W-1:0] calc_sum,
`endif
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   CAP  = {1'b1, {ADDR_W{1'b0}}};

  boot_state_t state, state_n;

  logic [ADDR_W-1:0] ptr;
  logic hs, full, wr, sum_ok;
  logic enter_load, drain_go, expire;

  assign s_ready = (state == LOAD);
  assign hs      = s_valid & s_ready;
  assign full    = (word_count == CAP);
  assign wr      = hs & ~full;

`ifdef IMEM_BOOT_CHECKSUM_EN
  assign sum_ok = ((calc_sum + s_data) == expected_sum);
`else
  assign sum_ok = 1'b1;
`endif

  assign drain_go = wr & s_last & sum_ok;

  always_comb begin
    state_n    = state;
    enter_load = 1'b0;
    unique case (state)
      IDLE, RUN, ERROR: begin
        if (start) begin
          state_n    = LOAD;
          enter_load = 1'b1;
        end
      end
      LOAD: begin
        // an overflowing word is dropped, never wrapped
        if (hs && full) begin
          state_n = ERROR;
        end else if (hs && s_last) begin
          state_n = sum_ok ? DRAIN : ERROR;
        end
      end
      DRAIN: begin
        if (expire) state_n = RUN;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ptr        <= BASE;
      word_count <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE;
      imem_wdata <= '0;
    end else begin
      state   <= state_n;
      imem_we <= wr;
      if (enter_load) begin
        ptr        <= BASE;
        word_count <= '0;
      end else if (wr) begin
        ptr        <= ptr + ADDR_W'(1);
        word_count <= word_count + (ADDR_W+1)'(1);
        imem_addr  <= ptr;
        imem_wdata <= s_data;
      end
    end
  end

`ifdef IMEM_BOOT_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      calc_sum <= '0;
    end else if (enter_load) begin
      calc_sum <= '0;
    end else if (wr) begin
      calc_sum <= calc_sum + s_data;
    end
  end
`endif

  boot_release_timer #(
    .DELAY (RELEASE_DELAY)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (drain_go),
    .en     (state == DRAIN),
    .expire (expire)
  );

  assign core_reset = (state != RUN);
  assign busy       = (state == LOAD) || (state == DRAIN);
  assign done       = (state == RUN);
  assign error      = (state == ERROR);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: default build and ADDR_W=2 side by side.
// Optional build macro: IMEM_BOOT_CHECKSUM_EN.
module tb_imem_boot_loader;

  localparam int RD = 4;
  localparam int P_IDLE  = 0;
  localparam int P_LOAD  = 1;
  localparam int P_DRAIN = 2;
  localparam int P_RUN   = 3;
  localparam int P_ERR   = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic s_valid = 1'b0;
  logic s_last = 1'b0;
  logic [31:0] s_data = '0;

  logic rdy0, we0, cr0, busy0, done0, err0;
  logic [7:0] addr0;
  logic [31:0] wd0;
  logic [8:0] wc0;
  logic rdy1, we1, cr1, busy1, done1, err1;
  logic [1:0] addr1;
  logic [31:0] wd1;
  logic [2:0] wc1;
  logic [31:0] cs0, cs1;
`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [31:0] exp_sum = '0;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int nwr0 = 0;
  int nwr1 = 0;
  int last_we = 0;
  int done_rise = 0;
  logic done_prev = 1'b0;

  int ph[2];
  int cnt[2];
  int left[2];
  int cap[2] = '{256, 4};
  bit m_we[2];
  int m_addr[2];
  logic [31:0] m_wd[2];
  logic [31:0] m_sum[2];

  always #5 clk = ~clk;

  imem_boot_loader u0 (
    .clk(clk), .reset(reset), .start(start),
    .s_valid(s_valid), .s_ready(rdy0),
    .s_data(s_data), .s_last(s_last),
    .imem_we(we0), .imem_addr(addr0),
    .imem_wdata(wd0), .core_reset(cr0),
    .busy(busy0), .done(done0), .error(err0),
`ifdef IMEM_BOOT_CHECKSUM_EN
    .expected_sum(exp_sum), .calc_sum(cs0),
`endif
    .word_count(wc0)
  );

  imem_boot_loader #(.ADDR_W(2)) u1 (
    .clk(clk), .reset(reset), .start(start),
    .s_valid(s_valid), .s_ready(rdy1),
    .s_data(s_data), .s_last(s_last),
    .imem_we(we1), .imem_addr(addr1),
    .imem_wdata(wd1), .core_reset(cr1),
    .busy(busy1), .done(done1), .error(err1),
`ifdef IMEM_BOOT_CHECKSUM_EN
    .expected_sum(exp_sum), .calc_sum(cs1),
`endif
    .word_count(wc1)
  );

`ifndef IMEM_BOOT_CHECKSUM_EN
  assign cs0 = '0;
  assign cs1 = '0;
`endif

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ph[i] = P_IDLE;
      cnt[i] = 0;
      left[i] = 0;
      m_we[i] = 1'b0;
      m_addr[i] = 0;
      m_wd[i] = '0;
      m_sum[i] = '0;
    end
  endtask

  // Reference: one clock edge of both loaders, from the spec's rules
  task automatic model_edge();
    bit bad;
    if (!reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      m_we[i] = 1'b0;
      case (ph[i])
        P_IDLE, P_RUN, P_ERR: begin
          if (start) begin
            ph[i] = P_LOAD;
            cnt[i] = 0;
            m_sum[i] = '0;
          end
        end
        P_LOAD: begin
          if (s_valid) begin
            if (cnt[i] == cap[i]) begin
              ph[i] = P_ERR;
            end else begin
              m_we[i] = 1'b1;
              m_addr[i] = cnt[i] % cap[i];
              m_wd[i] = s_data;
              m_sum[i] = m_sum[i] + s_data;
              cnt[i]++;
              if (s_last) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                bad = (m_sum[i] != exp_sum);
`else
                bad = 1'b0;
`endif
                ph[i] = bad ? P_ERR : P_DRAIN;
                left[i] = RD;
              end
            end
          end
        end
        P_DRAIN: begin
          left[i]--;
          if (left[i] == 0) ph[i] = P_RUN;
        end
        default: ph[i] = P_IDLE;
      endcase
    end
  endtask

  task automatic cmp(input int i, input logic rdy,
                     input logic we, input logic [31:0] ad,
                     input logic [31:0] wd, input logic [31:0] wc,
                     input logic cr, input logic bs,
                     input logic dn, input logic er,
                     input logic [31:0] cs);
    string p;
    p = (i == 0) ? "u0" : "u1";
    check({p, ".s_ready"}, rdy, ph[i] == P_LOAD);
    check({p, ".imem_we"}, we, m_we[i]);
    check({p, ".imem_addr"}, ad, m_addr[i]);
    check({p, ".imem_wdata"}, wd, m_wd[i]);
    check({p, ".word_count"}, wc, cnt[i]);
    check({p, ".core_reset"}, cr, ph[i] != P_RUN);
    check({p, ".busy"}, bs,
          ph[i] == P_LOAD || ph[i] == P_DRAIN);
    check({p, ".done"}, dn, ph[i] == P_RUN);
    check({p, ".error"}, er, ph[i] == P_ERR);
`ifdef IMEM_BOOT_CHECKSUM_EN
    check({p, ".calc_sum"}, cs, m_sum[i]);
`else
    if (cs !== '0) check({p, ".calc_sum"}, cs, 0);
`endif
  endtask

  task automatic compare_all();
    cmp(0, rdy0, we0, 32'(addr0), wd0, 32'(wc0),
        cr0, busy0, done0, err0, cs0);
    cmp(1, rdy1, we1, 32'(addr1), wd1, 32'(wc1),
        cr1, busy1, done1, err1, cs1);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    if (we0) begin
      nwr0++;
      last_we = cyc;
    end
    if (we1) nwr1++;
    if (done0 && !done_prev) done_rise = cyc;
    done_prev = done0;
    compare_all();
  endtask

  task automatic run_prog(input logic [31:0] w[$],
                          input bit vpat[$],
                          input int vpct,
                          input bit bad_sum,
                          input bit rnd_start,
                          input bit rst_drain);
    int k;
    int j;
    int guard;
`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [31:0] s;
    s = '0;
    foreach (w[x]) s = s + w[x];
    exp_sum = bad_sum ? s + 32'd1 : s;
`endif
    k = 0;
    j = 0;
    guard = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    while (k < w.size() && guard < 300) begin
      if (j < vpat.size()) s_valid = vpat[j];
      else s_valid = ($urandom_range(99) < vpct);
      s_data = s_valid ? w[k] : $urandom;
      s_last = s_valid ? (k == w.size() - 1)
                       : 1'($urandom_range(1));
      start = rnd_start && ($urandom_range(9) == 0);
      step();
      j++;
      guard++;
      if (s_valid) k++;
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    start = 1'b0;
    if (guard >= 300) check("load_timeout", 1, 0);
    if (rst_drain) begin
      step();
      step();
      reset = 1'b0;
      #1;
      model_reset();
      compare_all();
      check("rst_core_held", cr0, 1);
      step();
      reset = 1'b1;
      return;
    end
    guard = 0;
    while (ph[0] != P_RUN && ph[0] != P_ERR && guard < 40) begin
      step();
      guard++;
    end
    if (guard >= 40) check("release_timeout", 1, 0);
  endtask

  initial begin
    logic [31:0] w[$];
    bit vp[$];
    bit none[$];
    int n;
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    compare_all();
    step();
    step();
    check("rst_core_reset", cr0, 1);
    check("rst_addr", addr0, 0);
    reset = 1'b1;

    w = '{32'h20080005, 32'h20090003, 32'h01095020};
    nwr0 = 0;
    run_prog(w, none, 100, 0, 0, 0);
    check("prog3_writes", nwr0, 3);
    check("prog3_word_count", wc0, 3);
    check("prog3_done", done0, 1);
    check("prog3_core_reset", cr0, 0);
    check("release_delay", done_rise - last_we, RD);

    w = '{$urandom, $urandom, $urandom, $urandom};
    vp = '{1, 0, 1, 1, 0, 1};
    nwr0 = 0;
    run_prog(w, vp, 100, 0, 0, 0);
    check("gap_writes", nwr0, 4);
    check("gap_last_addr", addr0, 3);

    w = '{1, 2, 3, 4, 5};
    nwr1 = 0;
    run_prog(w, none, 100, 0, 0, 0);
    check("ovf_writes", nwr1, 4);
    check("ovf_error", err1, 1);
    check("ovf_core_reset", cr1, 1);
    check("ovf_word_count", wc1, 4);

    w = '{$urandom, $urandom};
    run_prog(w, none, 100, 0, 0, 1);
    w = '{32'hCAFE0001};
    run_prog(w, none, 100, 0, 0, 0);
    check("reload_addr", addr0, 0);
    check("reload_done", done0, 1);

`ifdef IMEM_BOOT_CHECKSUM_EN
    w = '{1, 2, 3};
    run_prog(w, none, 100, 0, 0, 0);
    check("sum_ok_done", done0, 1);
    check("sum_ok_calc", cs0, 6);
    run_prog(w, none, 100, 1, 0, 0);
    check("sum_bad_error", err0, 1);
    check("sum_bad_core_reset", cr0, 1);
`endif

    for (int it = 0; it < 25; it++) begin
      n = $urandom_range(6, 1);
      w = {};
      for (int x = 0; x < n; x++) w.push_back($urandom);
      run_prog(w, none, $urandom_range(100, 30),
               ($urandom_range(3) == 0), 1,
               ($urandom_range(4) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
